// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the CPU load/store path
// and a debug/loader port. CPU has priority; DBG has a starvation limit
// and a lockable burst mode.
// Ports: clk, rst_arb (sync, active-high);
//   cpu_req/we/addr/wdata -> cpu_ack/rdata/stall;
//   dbg_req/we/lock/addr/wdata -> dbg_ack/rdata;
//   mem_addr/wdata/we -> memory, mem_rdata <- memory (comb read);
//   grant_dbg = current grant is DBG.
module dm_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_arb,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_dbg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_DBG
  } state_t;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
  localparam logic [BW-1:0] B_MAX = BW'(MAX_BURST);

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic          dbg_force, dbg_keep;

  always_ff @(posedge clk) begin
    if (rst_arb) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      burst_cnt <= burst_nx;
    end
  end

  always_comb begin
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    cpu_rdata = '0;
    dbg_rdata = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (!rst_arb) begin
      unique case (state)
        S_CPU: begin
          cpu_ack   = cpu_req;
          cpu_rdata = mem_rdata;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          mem_we    = cpu_we & cpu_req;
        end
        S_DBG: begin
          dbg_ack   = dbg_req;
          dbg_rdata = mem_rdata;
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
          mem_we    = dbg_we & dbg_req;
        end
        default: ;
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign grant_dbg = (state == S_DBG) & ~rst_arb;

  // A DBG access being served this cycle is not pending, so the
  // starvation override only fires for a still-waiting request.
  assign dbg_force = dbg_req & ~dbg_ack & (wait_cnt >= W_MAX);
  assign dbg_keep  = (state == S_DBG) & dbg_lock & dbg_req
                   & (~cpu_req | (burst_cnt < B_MAX));

  always_comb begin
    state_nx = S_IDLE;
    if (dbg_force)    state_nx = S_DBG;
    else if (dbg_keep) state_nx = S_DBG;
    else if (cpu_req) state_nx = S_CPU;
    else if (dbg_req) state_nx = S_DBG;
  end

  always_comb begin
    wait_nx = wait_cnt;
    if (dbg_ack | ~dbg_req)   wait_nx = '0;
    else if (wait_cnt < W_MAX) wait_nx = wait_cnt + WW'(1);
  end

  // Counts consecutive DBG grant cycles, including the entry grant,
  // so a locked burst yields at most MAX_BURST accesses to a waiting CPU.
  always_comb begin
    burst_nx = burst_cnt;
    if (state_nx != S_DBG)      burst_nx = '0;
    else if (burst_cnt < B_MAX) burst_nx = burst_cnt + BW'(1);
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter
// with a small word-addressed memory model on the mem_* port.
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        rst_arb;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, grant_dbg;
  logic [31:0] mem [0:255] = '{default: 32'h0};
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst_arb(rst_arb),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .grant_dbg(grant_dbg)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic next_cyc;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs;
    cpu_req = 0; cpu_we = 0;
    cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic settle;
    clear_inputs();
    repeat (2) next_cyc();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_arb = 1; cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h40; cpu_wdata = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ntests++;
      if (mem_we !== 0 || cpu_ack !== 0 || grant_dbg !== 0) begin
        nfail++;
        $display("FAIL reset_outputs cyc%0d: we=%b ack=%b gnt=%b want 0",
                 i, mem_we, cpu_ack, grant_dbg);
      end
      next_cyc();
    end
    rst_arb = 0;
    @(negedge clk);
    ntests++;
    if (cpu_ack !== 0 || cpu_stall !== 1) begin
      nfail++;
      $display("FAIL reset_idle: ack=%b stall=%b want ack=0 stall=1",
               cpu_ack, cpu_stall);
    end
    cpu_req = 0;
    next_cyc();
    settle();
    ntests++;
    if (mem[16] !== 32'h0) begin
      nfail++;
      $display("FAIL reset_nowrite: mem=%h want 0", mem[16]);
    end
  endtask

  task automatic test_cpu_store_load;
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    ntests++;
    if (cpu_stall !== 1 || cpu_ack !== 0) begin
      nfail++;
      $display("FAIL cpu_c0: stall=%b ack=%b want 1 0", cpu_stall, cpu_ack);
    end
    next_cyc();
    @(negedge clk);
    ntests++;
    if (cpu_ack !== 1 || mem_we !== 1 || cpu_stall !== 0) begin
      nfail++;
      $display("FAIL cpu_store: ack=%b we=%b stall=%b want 1 1 0",
               cpu_ack, mem_we, cpu_stall);
    end
    next_cyc();
    cpu_we = 0;
    @(negedge clk);
    ntests++;
    if (cpu_ack !== 1 || mem_we !== 0 || cpu_stall !== 0 ||
        cpu_rdata !== 32'hDEADBEEF) begin
      nfail++;
      $display("FAIL cpu_load: ack=%b we=%b stall=%b rd=%h want 1 0 0 deadbeef",
               cpu_ack, mem_we, cpu_stall, cpu_rdata);
    end
    next_cyc();
    cpu_req = 0;
    @(negedge clk);
    ntests++;
    if (cpu_ack !== 0 || cpu_stall !== 0) begin
      nfail++;
      $display("FAIL cpu_done: ack=%b stall=%b want 0 0", cpu_ack, cpu_stall);
    end
    settle();
  endtask

  task automatic test_contention;
    logic [6:0] cpu_seen, dbg_seen;
    cpu_seen = 0; dbg_seen = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      cpu_seen[c] = cpu_ack;
      dbg_seen[c] = dbg_ack;
      if (c == 6) begin
        ntests++;
        if (dut.wait_cnt !== 0) begin
          nfail++;
          $display("FAIL contention_wait: wait_cnt=%0d want 0", dut.wait_cnt);
        end
      end
      next_cyc();
    end
    ntests++;
    if (cpu_seen !== 7'b1011110) begin
      nfail++;
      $display("FAIL contention_cpu: acks=%b want 1011110", cpu_seen);
    end
    ntests++;
    if (dbg_seen !== 7'b0100000) begin
      nfail++;
      $display("FAIL contention_dbg: acks=%b want 0100000", dbg_seen);
    end
    settle();
  endtask

  task automatic test_locked_burst;
    int d, c, dbefore;
    logic rd_ok;
    d = 0; c = 0; dbefore = -1; rd_ok = 1;
    dbg_lock = 1; dbg_we = 1; cpu_we = 0; cpu_addr = 32'h10;
    for (int cyc = 0; cyc < 40 && d < 12; cyc++) begin
      dbg_req = 1;
      dbg_addr = 32'h100 + 32'(d) * 4;
      dbg_wdata = 32'hA500_0000 | 32'(d);
      cpu_req = (d >= 2) && (c == 0);
      @(negedge clk);
      if (cpu_ack) begin
        c++; dbefore = d;
        if (cpu_rdata !== 32'hDEADBEEF) rd_ok = 0;
      end
      if (dbg_ack) d++;
      next_cyc();
    end
    clear_inputs();
    next_cyc();
    ntests++;
    if (d !== 12 || c !== 1) begin
      nfail++;
      $display("FAIL burst_counts: dbg=%0d cpu=%0d want 12 1", d, c);
    end
    ntests++;
    if (dbefore !== 8) begin
      nfail++;
      $display("FAIL burst_limit: dbg acks before cpu=%0d want 8", dbefore);
    end
    ntests++;
    if (!rd_ok) begin
      nfail++;
      $display("FAIL burst_cpu_read: rdata wrong want deadbeef");
    end
    for (int k = 0; k < 12; k++) begin
      ntests++;
      if (mem[64 + k] !== (32'hA500_0000 | 32'(k))) begin
        nfail++;
        $display("FAIL burst_mem[%0d]: got %h want %h",
                 k, mem[64 + k], 32'hA500_0000 | 32'(k));
      end
    end
    settle();
  endtask

  task automatic test_reset_mid_burst;
    int d;
    d = 0;
    dbg_lock = 1; dbg_we = 1;
    for (int cyc = 0; cyc < 20 && d < 4; cyc++) begin
      dbg_req = 1;
      dbg_addr = 32'h200 + 32'(d) * 4;
      dbg_wdata = 32'h5A00_0000 | 32'(d);
      @(negedge clk);
      if (dbg_ack) d++;
      next_cyc();
    end
    dbg_addr = 32'h210; dbg_wdata = 32'h5A00_0004;
    rst_arb = 1;
    @(negedge clk);
    ntests++;
    if (dbg_ack !== 0 || mem_we !== 0 || grant_dbg !== 0) begin
      nfail++;
      $display("FAIL rstburst_outputs: ack=%b we=%b gnt=%b want 0 0 0",
               dbg_ack, mem_we, grant_dbg);
    end
    next_cyc();
    rst_arb = 0;
    clear_inputs();
    @(negedge clk);
    ntests++;
    if (dut.burst_cnt !== 0 || grant_dbg !== 0) begin
      nfail++;
      $display("FAIL rstburst_state: burst=%0d gnt=%b want 0 0",
               dut.burst_cnt, grant_dbg);
    end
    next_cyc();
    ntests++;
    if (mem[132] !== 32'h0 || mem[131] !== 32'h5A00_0003) begin
      nfail++;
      $display("FAIL rstburst_mem: m4=%h m3=%h want 0 5a000003",
               mem[132], mem[131]);
    end
    settle();
  endtask

  task automatic test_illegal_drop;
    dbg_req = 1; dbg_we = 1;
    dbg_addr = 32'h300; dbg_wdata = 32'hCAFE_F00D;
    next_cyc();
    dbg_req = 0;
    @(negedge clk);
    ntests++;
    if (grant_dbg !== 1 || dbg_ack !== 0 || mem_we !== 0) begin
      nfail++;
      $display("FAIL drop_grant: gnt=%b ack=%b we=%b want 1 0 0",
               grant_dbg, dbg_ack, mem_we);
    end
    next_cyc();
    @(negedge clk);
    ntests++;
    if (grant_dbg !== 0 || mem[192] !== 32'h0) begin
      nfail++;
      $display("FAIL drop_idle: gnt=%b mem=%h want 0 0", grant_dbg, mem[192]);
    end
    settle();
  endtask

  initial begin
    rst_arb = 1;
    clear_inputs();
    #1;
    test_reset();
    test_cpu_store_load();
    test_contention();
    test_locked_burst();
    test_reset_mid_burst();
    test_illegal_drop();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
